// File: rtl/sha2_schedule_seq.sv
// sha2_schedule_seq
//   Per-round operand streamer for a SHA-2 compression core. A 16-word message
//   block is loaded over a valid/ready input. The block then produces ROUNDS
//   (t, K_t, W_t) tuples over a valid/ready output. W_t is expanded on the fly
//   in a 16-word sliding window, so win[0] always holds the word being offered.
//
//   MODE = 256 : WORD_W = 32, ROUNDS = 64
//   MODE = 512 : WORD_W = 64, ROUNDS = 80
//   Any other MODE stops elaboration.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort back to LOAD, discards the block in progress
//   in_valid   in_word carries a message word
//   in_ready   block accepts a word (LOAD state)
//   in_word    message word, W_0 first
//   out_valid  out_t/out_k/out_w/out_last carry a tuple (RUN state)
//   out_ready  consumer takes the tuple
//   out_t      round index 0..ROUNDS-1
//   out_k      round constant K_t
//   out_w      schedule word W_t
//   out_last   marks the t = ROUNDS-1 tuple
//   busy       high while tuples are being produced
module sha2_schedule_seq #(
  parameter  int MODE   = 256,
  localparam int WORD_W = (MODE == 512) ? 64 : 32,
  localparam int ROUNDS = (MODE == 512) ? 80 : 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_t,
  output logic [WORD_W-1:0] out_k,
  output logic [WORD_W-1:0] out_w,
  output logic              out_last,
  output logic              busy
);

  if ((MODE != 256) && (MODE != 512)) begin : g_bad_mode
    $error("sha2_schedule_seq: MODE must be 256 or 512");
  end

  localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [6:0]        t_p0;
  logic              vld_p0;
  logic [WORD_W-1:0] win_p0 [16];
  logic [WORD_W-1:0] w_next;
  logic              load_fire;
  logic              run_fire;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned      n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (MODE == 512) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else             return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (MODE == 512) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else             return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // SHA-512 constants. The SHA-256 constants are exactly the upper 32 bits of
  // the first 64 entries, so one table serves both modes.
  function automatic logic [WORD_W-1:0] k_rom(input logic [6:0] idx);
    logic [63:0] k;
    case (idx)
      7'd0:  k = 64'h428a2f98d728ae22;
      7'd1:  k = 64'h7137449123ef65cd;
      7'd2:  k = 64'hb5c0fbcfec4d3b2f;
      7'd3:  k = 64'he9b5dba58189dbbc;
      7'd4:  k = 64'h3956c25bf348b538;
      7'd5:  k = 64'h59f111f1b605d019;
      7'd6:  k = 64'h923f82a4af194f9b;
      7'd7:  k = 64'hab1c5ed5da6d8118;
      7'd8:  k = 64'hd807aa98a3030242;
      7'd9:  k = 64'h12835b0145706fbe;
      7'd10: k = 64'h243185be4ee4b28c;
      7'd11: k = 64'h550c7dc3d5ffb4e2;
      7'd12: k = 64'h72be5d74f27b896f;
      7'd13: k = 64'h80deb1fe3b1696b1;
      7'd14: k = 64'h9bdc06a725c71235;
      7'd15: k = 64'hc19bf174cf692694;
      7'd16: k = 64'he49b69c19ef14ad2;
      7'd17: k = 64'hefbe4786384f25e3;
      7'd18: k = 64'h0fc19dc68b8cd5b5;
      7'd19: k = 64'h240ca1cc77ac9c65;
      7'd20: k = 64'h2de92c6f592b0275;
      7'd21: k = 64'h4a7484aa6ea6e483;
      7'd22: k = 64'h5cb0a9dcbd41fbd4;
      7'd23: k = 64'h76f988da831153b5;
      7'd24: k = 64'h983e5152ee66dfab;
      7'd25: k = 64'ha831c66d2db43210;
      7'd26: k = 64'hb00327c898fb213f;
      7'd27: k = 64'hbf597fc7beef0ee4;
      7'd28: k = 64'hc6e00bf33da88fc2;
      7'd29: k = 64'hd5a79147930aa725;
      7'd30: k = 64'h06ca6351e003826f;
      7'd31: k = 64'h142929670a0e6e70;
      7'd32: k = 64'h27b70a8546d22ffc;
      7'd33: k = 64'h2e1b21385c26c926;
      7'd34: k = 64'h4d2c6dfc5ac42aed;
      7'd35: k = 64'h53380d139d95b3df;
      7'd36: k = 64'h650a73548baf63de;
      7'd37: k = 64'h766a0abb3c77b2a8;
      7'd38: k = 64'h81c2c92e47edaee6;
      7'd39: k = 64'h92722c851482353b;
      7'd40: k = 64'ha2bfe8a14cf10364;
      7'd41: k = 64'ha81a664bbc423001;
      7'd42: k = 64'hc24b8b70d0f89791;
      7'd43: k = 64'hc76c51a30654be30;
      7'd44: k = 64'hd192e819d6ef5218;
      7'd45: k = 64'hd69906245565a910;
      7'd46: k = 64'hf40e35855771202a;
      7'd47: k = 64'h106aa07032bbd1b8;
      7'd48: k = 64'h19a4c116b8d2d0c8;
      7'd49: k = 64'h1e376c085141ab53;
      7'd50: k = 64'h2748774cdf8eeb99;
      7'd51: k = 64'h34b0bcb5e19b48a8;
      7'd52: k = 64'h391c0cb3c5c95a63;
      7'd53: k = 64'h4ed8aa4ae3418acb;
      7'd54: k = 64'h5b9cca4f7763e373;
      7'd55: k = 64'h682e6ff3d6b2b8a3;
      7'd56: k = 64'h748f82ee5defb2fc;
      7'd57: k = 64'h78a5636f43172f60;
      7'd58: k = 64'h84c87814a1f0ab72;
      7'd59: k = 64'h8cc702081a6439ec;
      7'd60: k = 64'h90befffa23631e28;
      7'd61: k = 64'ha4506cebde82bde9;
      7'd62: k = 64'hbef9a3f7b2c67915;
      7'd63: k = 64'hc67178f2e372532b;
      7'd64: k = 64'hca273eceea26619c;
      7'd65: k = 64'hd186b8c721c0c207;
      7'd66: k = 64'heada7dd6cde0eb1e;
      7'd67: k = 64'hf57d4f7fee6ed178;
      7'd68: k = 64'h06f067aa72176fba;
      7'd69: k = 64'h0a637dc5a2c898a6;
      7'd70: k = 64'h113f9804bef90dae;
      7'd71: k = 64'h1b710b35131c471b;
      7'd72: k = 64'h28db77f523047d84;
      7'd73: k = 64'h32caab7b40c72493;
      7'd74: k = 64'h3c9ebe0a15c9bebc;
      7'd75: k = 64'h431d67c49c100d4c;
      7'd76: k = 64'h4cc5d4becb3e42b6;
      7'd77: k = 64'h597f299cfc657e2a;
      7'd78: k = 64'h5fcb6fab3ad6faec;
      7'd79: k = 64'h6c44198c4a475817;
      default: k = '0;
    endcase
    return WORD_W'(k >> (64 - WORD_W));
  endfunction

  // clear outranks both handshakes, so neither fire term can be set with it.
  assign load_fire = !clear && (state == S_LOAD) && in_valid && in_ready;
  assign run_fire  = !clear && (state == S_RUN) && vld_p0 && out_ready;

  // W_{t+16} from the window that currently holds W_t..W_{t+15}.
  assign w_next = sigma1(win_p0[14]) + win_p0[9] + sigma0(win_p0[1]) + win_p0[0];

  // ---- stage p0: control registers; outputs come straight from here ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      cnt      <= '0;
      t_p0     <= '0;
      vld_p0   <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      out_last <= 1'b0;
    end else if (clear) begin
      state    <= S_LOAD;
      cnt      <= '0;
      t_p0     <= '0;
      vld_p0   <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_fire) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state    <= S_RUN;
              t_p0     <= '0;
              vld_p0   <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              out_last <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (run_fire) begin
            if (t_p0 == T_LAST) begin
              state    <= S_LOAD;
              cnt      <= '0;
              t_p0     <= '0;
              vld_p0   <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              out_last <= 1'b0;
            end else begin
              t_p0     <= t_p0 + 7'd1;
              out_last <= ((t_p0 + 7'd1) == T_LAST);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // ---- stage p0: schedule window; loads in LOAD, slides on each handshake ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_p0[i] <= '0;
    end else if (load_fire) begin
      win_p0[cnt] <= in_word;
    end else if (run_fire) begin
      for (int i = 0; i < 15; i++) win_p0[i] <= win_p0[i+1];
      win_p0[15] <= w_next;
    end
  end

  assign out_valid = vld_p0;
  assign out_t     = t_p0;
  assign out_w     = win_p0[0];
  assign out_k     = k_rom(t_p0);

endmodule

// File: doc/sha2_schedule_seq.md
Name: sha2_schedule_seq

Overview:
- Streams per-round operands for the SHA-2 compression core: round index t, round constant K_t and message-schedule word W_t.
- Accepts one 16-word message block over a valid/ready input, then emits ROUNDS (t, K_t, W_t) tuples over a valid/ready output.
- Sits between the padding/block buffer and the round datapath.
- Successor to the fixed 64-entry SHA-256 constant table: parametrised for SHA-256 and SHA-512, with an on-the-fly W expansion.

Parameters:
- MODE, 256, algorithm family. 256 selects WORD_W=32, ROUNDS=64; 512 selects WORD_W=64, ROUNDS=80. Any other value is an elaboration error.
- WORD_W, derived (not overridable), word width in bits.
- ROUNDS, derived (not overridable), round count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; returns to LOAD and discards the block.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts a word.
- in_word  in  WORD_W  message word, big-endian word order, W_0 first.
- out_valid  out  1  out_t/out_k/out_w are valid.
- out_ready  in  1  consumer accepts the tuple.
- out_t  out  7  round index 0..ROUNDS-1.
- out_k  out  WORD_W  FIPS 180-4 constant K_t for MODE.
- out_w  out  WORD_W  schedule word W_t.
- out_last  out  1  high with the t=ROUNDS-1 tuple.
- busy  out  1  high in RUN.

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n. While rst_n=0:
  - state=LOAD, word counter=0, t=0, window cleared;
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_t=0, out_w=0, out_k=K_0.
- Storage: 16-entry WORD_W window register, win[0..15]. In RUN, win[0]=W_t.
- LOAD state:
  - in_ready=1, out_valid=0.
  - Each in_valid&in_ready edge writes in_word to win[cnt] and increments cnt.
  - The accept with cnt=15 moves to RUN with t=0.
  - out_valid=1 in the cycle after that edge (one-cycle latency from last word to first tuple).
- RUN state:
  - in_ready=0, busy=1, out_valid=1.
  - out_w=win[0], out_k=ROM[t], out_t=t. All are driven from registers or a ROM indexed by the registered t; no combinational path from out_ready to out_*.
  - On out_valid&out_ready:
    - window shifts: win[i] <= win[i+1];
    - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^WORD_W;
    - t <= t+1.
  - Stall (out_ready=0): all outputs hold stable.
  - Handshake with t=ROUNDS-1 (out_last=1): back to LOAD, cnt=0, t=0, out_valid=0 next cycle.
  - Schedule words computed past W_{ROUNDS-1} are never emitted.
- Sigma functions:
  - MODE 256: σ0=ROTR7^ROTR18^SHR3; σ1=ROTR17^ROTR19^SHR10.
  - MODE 512: σ0=ROTR1^ROTR8^SHR7; σ1=ROTR19^ROTR61^SHR6.
- Constants: ROM holds 64 (MODE 256) or 80 (MODE 512) FIPS 180-4 constants. For MODE 512, the upper 32 bits of K_0..K_63 equal the SHA-256 constants.
- clear:
  - Has priority over every handshake in the same cycle.
  - Next state is LOAD with cnt=0, t=0, out_valid=0, busy=0; the window contents become don't-care.
  - A word presented with clear is not accepted.
- Reset mid-block or mid-RUN: immediate return to the reset values above; the partial block is lost.
- Back-to-back blocks: the next block's first word may be accepted in the cycle after the out_last handshake (in_ready=1 there). There is no overlap of LOAD and RUN.

Test Plan:
- MODE 256, "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 → 64 tuples in 64 consecutive cycles:
  - t=0: K=0x428a2f98, W=0x61626380;
  - t=16: W=0x61626380;
  - t=17: W=0x000F0000;
  - t=63: K=0xc67178f2 with out_last=1.
- Same block, out_ready toggled pseudo-randomly → identical tuple sequence; outputs stable during every stall; exactly 64 handshakes; then in_ready=1.
- MODE 512, 16 zero words → t=0: K=0x428a2f98d728ae22, W=0; all W=0; t=79: K=0x6c44198c4a475817, out_last=1.
- clear asserted after 9 words, then a fresh 16-word "abc" block → output matches the first scenario exactly. clear asserted at t=30 in RUN → out_valid=0 next cycle, in_ready=1.
- rst_n pulsed low asynchronously mid-RUN (between edges) → out_valid, busy, out_last drop immediately; in_ready=1; the next block processes correctly.
- Two blocks back-to-back with in_valid held high → first word of block 2 is accepted the cycle after block 1's out_last handshake; block 2 tuples are correct.
